z80_io_uart: RTL and testbench

Parametrised, IO-mapped UART peripheral for the A-Z80 host boards. It replaces the transmit-only UART and its ad-hoc busy-flag decode with one self-contained block. The block provides a TX FIFO, an RX path with its own FIFO, sticky error flags, and an IM2 vectored interrupt. It attaches directly to the Z80 control, address and data pins and to the board UART pins.

---
 rtl/z80_io_uart.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_z80_io_uart.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_uart.sv
`default_nettype none
// ============================================================================
// Module      : z80_io_uart
// Description : IO-mapped Z80 UART with TX/RX FIFOs, sticky error flags and
//               an IM2 vectored interrupt.
// Revision    : 1.0
// ============================================================================
module z80_io_uart #(
    parameter int         CLK_HZ    = 50000000,
    parameter int         BAUD      = 115200,
    parameter int         TX_DEPTH  = 16,
    parameter int         RX_DEPTH  = 4,
    parameter logic [7:0] BASE_PORT = 8'h00,
    parameter logic [7:0] VECTOR    = 8'h80
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic       nWR,
    input  logic       nM1,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic       nINT,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int              C_DIV       = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int              C_CW        = $clog2(C_DIV);
    localparam logic [C_CW-1:0] C_DIV_LAST  = C_CW'(C_DIV - 1);
    localparam logic [C_CW-1:0] C_HALF_LAST = C_CW'(C_DIV / 2 - 1);
    localparam logic [C_CW-1:0] C_CNT_ONE   = C_CW'(1);
    localparam int              C_TAW       = $clog2(TX_DEPTH);
    localparam int              C_RAW       = $clog2(RX_DEPTH);
    localparam logic [7:0]      C_PORT_STAT = BASE_PORT + 8'd1;
    localparam logic [7:0]      C_PORT_CTRL = BASE_PORT + 8'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // ---------------------------------------------------------------- decode
    logic       w_sel_data, w_sel_stat, w_sel_ctrl, w_sel_any;
    logic       w_io_wr, w_io_rd, w_wr_edge, w_rd_end, w_ack;
    logic       r_io_wr_d, r_io_rd_d;
    logic [1:0] r_rd_sel;

    assign w_sel_data = (A == BASE_PORT);
    assign w_sel_stat = (A == C_PORT_STAT);
    assign w_sel_ctrl = (A == C_PORT_CTRL);
    assign w_sel_any  = w_sel_data | w_sel_stat | w_sel_ctrl;
    assign w_io_wr    = !nIORQ & nM1 & nRD & !nWR & w_sel_any;
    assign w_io_rd    = !nIORQ & nM1 & !nRD & nWR & w_sel_any;
    assign w_wr_edge  = w_io_wr & !r_io_wr_d;
    assign w_rd_end   = r_io_rd_d & !w_io_rd;
    assign w_ack      = !nM1 & !nIORQ;

    // --------------------------------------------------------------- TX FIFO
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [C_TAW:0] r_tx_wp, r_tx_rp;
    logic           w_tx_empty, w_tx_full, w_tx_pop, w_tx_push, w_tx_push_req;
    logic [7:0]     w_tx_head;

    tx_state_t       r_tx_st;
    logic [C_CW-1:0] r_tx_cnt;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_sh;
    logic            r_txd;
    logic            w_tx_bdone, w_tx_busy;

    assign w_tx_empty    = (r_tx_wp == r_tx_rp);
    assign w_tx_full     = (r_tx_wp[C_TAW] != r_tx_rp[C_TAW]) &&
                           (r_tx_wp[C_TAW-1:0] == r_tx_rp[C_TAW-1:0]);
    assign w_tx_head     = r_tx_mem[r_tx_rp[C_TAW-1:0]];
    assign w_tx_bdone    = (r_tx_cnt == C_DIV_LAST);
    assign w_tx_busy     = (r_tx_st != TX_IDLE);
    // The FSM pops when idle or at the last stop cycle, giving gapless frames.
    assign w_tx_pop      = !w_tx_empty &&
                           ((r_tx_st == TX_IDLE) || ((r_tx_st == TX_STOP) && w_tx_bdone));
    assign w_tx_push_req = w_wr_edge & w_sel_data;
    assign w_tx_push     = w_tx_push_req & (!w_tx_full | w_tx_pop);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + (C_TAW+1)'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + (C_TAW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[C_TAW-1:0]] <= D_in;
    end

    // ---------------------------------------------------------------- TX FSM
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_tx_st  <= TX_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_txd    <= 1'b1;
        end else begin
            case (r_tx_st)
                TX_IDLE: begin
                    if (!w_tx_empty) begin
                        r_tx_sh  <= w_tx_head;
                        r_txd    <= 1'b0;
                        r_tx_cnt <= '0;
                        r_tx_st  <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_bdone) begin
                        r_tx_cnt <= '0;
                        r_tx_bit <= '0;
                        r_txd    <= r_tx_sh[0];
                        r_tx_st  <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bdone) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_tx_st <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_txd    <= r_tx_sh[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bdone) begin
                        r_tx_cnt <= '0;
                        if (!w_tx_empty) begin
                            r_tx_sh <= w_tx_head;
                            r_txd   <= 1'b0;
                            r_tx_st <= TX_START;
                        end else begin
                            r_tx_st <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_CNT_ONE;
                    end
                end
                default: r_tx_st <= TX_IDLE;
            endcase
        end
    end

    assign uart_txd = r_txd;

    // ---------------------------------------------------------------- RX FSM
    rx_state_t       r_rx_st;
    logic [C_CW-1:0] r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_sh;
    logic            r_rx_s1, r_rx_s2, r_rx_prev;
    logic            w_rx_stop_smp, w_rx_push_req, w_rx_frm_set;

    assign w_rx_stop_smp = (r_rx_st == RX_STOP) && (r_rx_cnt == C_DIV_LAST);
    assign w_rx_push_req = w_rx_stop_smp & r_rx_s2;
    assign w_rx_frm_set  = w_rx_stop_smp & !r_rx_s2;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            case (r_rx_st)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start re-check rejects glitches shorter than half a bit.
                    if (r_rx_cnt == C_HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + C_CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == C_DIV_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_st  <= RX_STOP;
                        else                  r_rx_bit <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + C_CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == C_DIV_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + C_CNT_ONE;
                    end
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- RX FIFO
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [C_RAW:0] r_rx_wp, r_rx_rp;
    logic           w_rx_empty, w_rx_full, w_rx_pop, w_rx_push;
    logic [7:0]     w_rx_head;

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[C_RAW] != r_rx_rp[C_RAW]) &&
                        (r_rx_wp[C_RAW-1:0] == r_rx_rp[C_RAW-1:0]);
    assign w_rx_head  = r_rx_mem[r_rx_rp[C_RAW-1:0]];
    assign w_rx_pop   = w_rd_end & r_rd_sel[0] & !w_rx_empty;
    assign w_rx_push  = w_rx_push_req & (!w_rx_full | w_rx_pop);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + (C_RAW+1)'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + (C_RAW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[C_RAW-1:0]] <= r_rx_sh;
    end

    // ------------------------------------------- control, flags, interrupt
    logic [1:0] r_ctrl;
    logic       r_tx_ovf, r_rx_ovr, r_frm_err, r_nint;
    logic       w_stat_clr, w_int_req;
    logic [7:0] w_status;

    assign w_stat_clr = w_rd_end & r_rd_sel[1];
    assign w_int_req  = (r_ctrl[0] & !w_rx_empty) |
                        (r_ctrl[1] & w_tx_empty & !w_tx_busy);
    assign w_status   = {1'b0, r_tx_ovf, r_frm_err, w_tx_busy,
                         r_rx_ovr, !w_rx_empty, w_tx_empty, w_tx_full};

    // Sticky flags: a set in the same cycle as the clear-on-read wins.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_io_wr_d <= 1'b0;
            r_io_rd_d <= 1'b0;
            r_rd_sel  <= '0;
            r_ctrl    <= '0;
            r_tx_ovf  <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_frm_err <= 1'b0;
            r_nint    <= 1'b1;
        end else begin
            r_io_wr_d <= w_io_wr;
            r_io_rd_d <= w_io_rd;
            if (w_io_rd) r_rd_sel <= {w_sel_stat, w_sel_data};
            if (w_wr_edge && w_sel_ctrl) r_ctrl <= D_in[1:0];
            if (w_tx_push_req && w_tx_full && !w_tx_pop) r_tx_ovf <= 1'b1;
            else if (w_stat_clr)                         r_tx_ovf <= 1'b0;
            if (w_rx_push_req && w_rx_full && !w_rx_pop) r_rx_ovr <= 1'b1;
            else if (w_stat_clr)                         r_rx_ovr <= 1'b0;
            if (w_rx_frm_set)    r_frm_err <= 1'b1;
            else if (w_stat_clr) r_frm_err <= 1'b0;
            r_nint <= !w_int_req;
        end
    end

    assign nINT = r_nint;

    always_comb begin
        D_oe  = 1'b0;
        D_out = 8'h00;
        if (w_ack) begin
            if (!r_nint) begin
                D_oe  = 1'b1;
                D_out = VECTOR;
            end
        end else if (w_io_rd) begin
            D_oe = 1'b1;
            if (w_sel_data)      D_out = w_rx_empty ? 8'h00 : w_rx_head;
            else if (w_sel_stat) D_out = w_status;
            else                 D_out = {6'b0, r_ctrl};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z80_io_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80_io_uart
// Description : Directed self-checking bench for z80_io_uart (DIV = 10).
// Revision    : 1.0
// ============================================================================
module tb_z80_io_uart;

    localparam logic [7:0] C_DATA = 8'h00;
    localparam logic [7:0] C_STAT = 8'h01;
    localparam logic [7:0] C_CTRL = 8'h02;

    logic       clk = 1'b0;
    logic       nreset, niorq, nrd, nwr, nm1, rxd;
    logic [7:0] a, d_in, d_out;
    logic       d_oe, nint, txd;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_wr_cyc = 0;

    // line monitor results: decoded bytes, start cycles, framing ok
    logic [7:0] mon_q[$];
    int         mon_start_q[$];
    logic       mon_ok_q[$];
    int         mon_last_fall = -1;

    z80_io_uart #(
        .CLK_HZ(1000000), .BAUD(100000), .TX_DEPTH(16), .RX_DEPTH(4),
        .BASE_PORT(8'h00), .VECTOR(8'h80)
    ) dut (
        .CLK(clk), .nRESET(nreset), .nIORQ(niorq), .nRD(nrd), .nWR(nwr),
        .nM1(nm1), .A(a), .D_in(d_in), .D_out(d_out), .D_oe(d_oe),
        .nINT(nint), .uart_rxd(rxd), .uart_txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Independent UART receiver on txd, sampling mid-bit.
    initial begin : g_tx_mon
        logic       prev;
        logic [7:0] b;
        logic       st0, sp;
        int         s;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txd === 1'b0) begin
                s = cyc;
                mon_last_fall = s;
                repeat (5) @(negedge clk);
                st0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = txd;
                end
                repeat (10) @(negedge clk);
                sp = txd;
                mon_q.push_back(b);
                mon_start_q.push_back(s);
                mon_ok_q.push_back(!st0 && sp);
                prev = sp;
            end else begin
                prev = txd;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        a = addr; d_in = data; niorq = 1'b0; nwr = 1'b0;
        last_wr_cyc = cyc;
        repeat (2) @(posedge clk); #1;
        niorq = 1'b1; nwr = 1'b1;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] data, output logic oe);
        @(posedge clk); #1;
        a = addr; niorq = 1'b0; nrd = 1'b0;
        @(negedge clk);
        data = d_out; oe = d_oe;
        repeat (2) @(posedge clk); #1;
        niorq = 1'b1; nrd = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        io_read(addr, d, oe);
        chk({tag, "_oe"}, {31'b0, oe}, 32'd1);
        chk(tag, {24'b0, d}, {24'b0, exp});
    endtask

    task automatic int_ack(output logic [7:0] data, output logic oe);
        @(posedge clk); #1;
        nm1 = 1'b0; niorq = 1'b0;
        @(negedge clk);
        data = d_out; oe = d_oe;
        @(posedge clk); #1;
        nm1 = 1'b1; niorq = 1'b1;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 rxd = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (10) @(posedge clk);
        end
        #1 rxd = stop;
        repeat (10) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("tx_frames_seen", mon_q.size(), n);
    endtask

    task automatic mon_clear();
        mon_q.delete();
        mon_start_q.delete();
        mon_ok_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       oe;
        int         w0;
        int         k;

        nreset = 1'b0; niorq = 1'b1; nrd = 1'b1; nwr = 1'b1; nm1 = 1'b1;
        a = 8'h00; d_in = 8'h00; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_nint", {31'b0, nint}, 32'd1);
        chk("rst_doe", {31'b0, d_oe}, 32'd0);
        chk("rst_dout", {24'b0, d_out}, 32'h00);
        read_chk("rst_status", C_STAT, 8'h02);
        read_chk("rst_ctrl", C_CTRL, 8'h00);
        read_chk("rst_rx_empty", C_DATA, 8'h00);

        // single byte transmit
        io_write(C_DATA, 8'h55);
        wait_frames(1, 300);
        if (mon_q.size() > 0) begin
            chk("tx55_byte", {24'b0, mon_q[0]}, 32'h55);
            chk("tx55_framing", {31'b0, mon_ok_q[0]}, 32'd1);
            chk("tx55_latency", mon_start_q[0] - last_wr_cyc, 32'd2);
        end
        repeat (10) @(posedge clk);
        read_chk("tx55_status_after", C_STAT, 8'h02);
        mon_clear();

        // TX overflow: 18 writes, 17 frames, gapless
        for (int i = 0; i < 18; i++) io_write(C_DATA, 8'(i + 1));
        read_chk("txovf_status1", C_STAT, 8'h51);
        read_chk("txovf_status2", C_STAT, 8'h11);
        wait_frames(17, 2200);
        for (int i = 0; i < 17 && i < mon_q.size(); i++) begin
            chk($sformatf("txovf_byte%0d", i), {24'b0, mon_q[i]}, 32'(i + 1));
            if (i > 0)
                chk($sformatf("txovf_gap%0d", i), mon_start_q[i] - mon_start_q[i-1], 32'd100);
        end
        repeat (150) @(posedge clk);
        chk("txovf_no_18th", mon_q.size(), 32'd17);
        read_chk("txovf_status_idle", C_STAT, 8'h02);
        mon_clear();

        // RX with interrupt
        io_write(C_CTRL, 8'h01);
        read_chk("ctrl_readback", C_CTRL, 8'h01);
        rx_send(8'hA3, 1'b1);
        @(negedge clk);
        chk("rxint_nint_low", {31'b0, nint}, 32'd0);
        read_chk("rxint_status", C_STAT, 8'h06);
        int_ack(d, oe);
        chk("ack_oe", {31'b0, oe}, 32'd1);
        chk("ack_vector", {24'b0, d}, 32'h80);
        read_chk("rxint_data", C_DATA, 8'hA3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rxint_nint_high", {31'b0, nint}, 32'd1);
        read_chk("rxint_status_after", C_STAT, 8'h02);
        int_ack(d, oe);
        chk("ack_no_int_oe", {31'b0, oe}, 32'd0);

        // RX glitch and framing error
        @(posedge clk); #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (30) @(posedge clk);
        read_chk("glitch_status", C_STAT, 8'h02);
        rx_send(8'h5A, 1'b0);
        read_chk("frm_status", C_STAT, 8'h22);
        read_chk("frm_status_cleared", C_STAT, 8'h02);
        read_chk("frm_no_byte", C_DATA, 8'h00);

        // RX overrun
        for (int v = 1; v <= 5; v++) rx_send(8'(v), 1'b1);
        read_chk("ovr_status", C_STAT, 8'h0E);
        for (int v = 1; v <= 4; v++) read_chk($sformatf("ovr_data%0d", v), C_DATA, 8'(v));
        read_chk("ovr_empty", C_DATA, 8'h00);
        read_chk("ovr_status_after", C_STAT, 8'h02);

        // reset in the middle of a frame (bit 3 of 0xF0 is 0)
        mon_clear();
        io_write(C_DATA, 8'hF0);
        w0 = last_wr_cyc;
        io_write(C_DATA, 8'h33);
        k = 0;
        while (mon_last_fall < w0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_start_seen", {31'b0, (mon_last_fall >= w0)}, 32'd1);
        k = 0;
        while (cyc < mon_last_fall + 43 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_bit3_low", {31'b0, txd}, 32'd0);
        @(posedge clk); #1 nreset = 1'b0;
        @(posedge clk); #1 nreset = 1'b1;
        @(negedge clk);
        chk("rst_mid_txd_high", {31'b0, txd}, 32'd1);
        chk("rst_mid_nint", {31'b0, nint}, 32'd1);
        read_chk("rst_mid_status", C_STAT, 8'h02);
        read_chk("rst_mid_ctrl", C_CTRL, 8'h00);
        repeat (150) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_line_idle", {31'b0, txd}, 32'd1);
        read_chk("rst_mid_fifo_empty", C_STAT, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
